// File: rtl/mul_pkg.sv
// Shared constants for the pipelined multiplier and its half-width partial-product blocks.
package mul_pkg;
    localparam int MUL_WIDTH_DEF   = 32;
    localparam int MUL_LATENCY_DEF = 6;
    localparam int MUL_HALF_DEF    = MUL_WIDTH_DEF / 2;
endpackage

// File: rtl/mul_half_pp.sv
// Registered HALF_W x HALF_W -> 2*HALF_W unsigned multiplier; one partial product of the core.
module mul_half_pp
    import mul_pkg::*;
#(
    parameter int HALF_W = MUL_HALF_DEF
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic [HALF_W-1:0]     a,
    input  logic [HALF_W-1:0]     b,
    output logic [2*HALF_W-1:0]   p
);

    logic [2*HALF_W-1:0] p_d;
    logic [2*HALF_W-1:0] p_q;

    always_comb begin
        p_d = {{HALF_W{1'b0}}, a} * {{HALF_W{1'b0}}, b};
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/pipelined_multiplier.sv
// Fully pipelined unsigned WIDTH x WIDTH -> 2*WIDTH multiplier built from four half-width products.
// WIDTH must be even and >= 4; LATENCY must lie in 3..6 (shorter pipelines fold the late adders).
module pipelined_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH   = MUL_WIDTH_DEF,
    parameter int LATENCY = MUL_LATENCY_DEF
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   P
);

    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;

    // Stage 1: operand capture
    logic [WIDTH-1:0] a_p1_d, a_p1_q;
    logic [WIDTH-1:0] b_p1_d, b_p1_q;

    always_comb begin
        a_p1_d = A;
        b_p1_d = B;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            a_p1_q <= '0;
            b_p1_q <= '0;
        end else begin
            a_p1_q <= a_p1_d;
            b_p1_q <= b_p1_d;
        end
    end

    // Stage 2: four registered half-products
    logic [WIDTH-1:0] pp_ll_p2, pp_lh_p2, pp_hl_p2, pp_hh_p2;

    mul_half_pp #(.HALF_W(H)) u_pp_ll (.CLK(CLK), .rst_n(rst_n),
        .a(a_p1_q[H-1:0]),     .b(b_p1_q[H-1:0]),     .p(pp_ll_p2));
    mul_half_pp #(.HALF_W(H)) u_pp_lh (.CLK(CLK), .rst_n(rst_n),
        .a(a_p1_q[H-1:0]),     .b(b_p1_q[WIDTH-1:H]), .p(pp_lh_p2));
    mul_half_pp #(.HALF_W(H)) u_pp_hl (.CLK(CLK), .rst_n(rst_n),
        .a(a_p1_q[WIDTH-1:H]), .b(b_p1_q[H-1:0]),     .p(pp_hl_p2));
    mul_half_pp #(.HALF_W(H)) u_pp_hh (.CLK(CLK), .rst_n(rst_n),
        .a(a_p1_q[WIDTH-1:H]), .b(b_p1_q[WIDTH-1:H]), .p(pp_hh_p2));

    // Stage 3: cross-term sum keeps its carry, hence WIDTH+1 bits
    logic [WIDTH:0]   cross_p3_d, cross_p3;
    logic [WIDTH-1:0] ll_p3_d, ll_p3, hh_p3_d, hh_p3;

    always_comb begin
        cross_p3_d = {1'b0, pp_lh_p2} + {1'b0, pp_hl_p2};
        ll_p3_d    = pp_ll_p2;
        hh_p3_d    = pp_hh_p2;
    end

    if (LATENCY >= 4) begin : g_p3_reg
        logic [WIDTH:0]   cross_p3_q;
        logic [WIDTH-1:0] ll_p3_q, hh_p3_q;
        always_ff @(posedge CLK or negedge rst_n) begin
            if (!rst_n) begin
                cross_p3_q <= '0;
                ll_p3_q    <= '0;
                hh_p3_q    <= '0;
            end else begin
                cross_p3_q <= cross_p3_d;
                ll_p3_q    <= ll_p3_d;
                hh_p3_q    <= hh_p3_d;
            end
        end
        assign cross_p3 = cross_p3_q;
        assign ll_p3    = ll_p3_q;
        assign hh_p3    = hh_p3_q;
    end else begin : g_p3_comb
        assign cross_p3 = cross_p3_d;
        assign ll_p3    = ll_p3_d;
        assign hh_p3    = hh_p3_d;
    end

    // Stage 4: fold the cross term into the low half; the high half-product passes along
    logic [PW-1:0]    low_p4_d, low_p4;
    logic [WIDTH-1:0] high_p4_d, high_p4;

    always_comb begin
        low_p4_d  = {{WIDTH{1'b0}}, ll_p3} + ({{(WIDTH-1){1'b0}}, cross_p3} << H);
        high_p4_d = hh_p3;
    end

    if (LATENCY >= 5) begin : g_p4_reg
        logic [PW-1:0]    low_p4_q;
        logic [WIDTH-1:0] high_p4_q;
        always_ff @(posedge CLK or negedge rst_n) begin
            if (!rst_n) begin
                low_p4_q  <= '0;
                high_p4_q <= '0;
            end else begin
                low_p4_q  <= low_p4_d;
                high_p4_q <= high_p4_d;
            end
        end
        assign low_p4  = low_p4_q;
        assign high_p4 = high_p4_q;
    end else begin : g_p4_comb
        assign low_p4  = low_p4_d;
        assign high_p4 = high_p4_d;
    end

    // Stage 5: final sum; the full product always fits in 2*WIDTH bits
    logic [PW-1:0] fin_p5_d, fin_p5;

    always_comb begin
        fin_p5_d = low_p4 + {high_p4, {WIDTH{1'b0}}};
    end

    if (LATENCY >= 6) begin : g_p5_reg
        logic [PW-1:0] fin_p5_q;
        always_ff @(posedge CLK or negedge rst_n) begin
            if (!rst_n) begin
                fin_p5_q <= '0;
            end else begin
                fin_p5_q <= fin_p5_d;
            end
        end
        assign fin_p5 = fin_p5_q;
    end else begin : g_p5_comb
        assign fin_p5 = fin_p5_d;
    end

    // Stage 6: output register, always present so P is registered at every latency
    logic [PW-1:0] p_p6_d, p_p6_q;

    always_comb begin
        p_p6_d = fin_p5;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            p_p6_q <= '0;
        end else begin
            p_p6_q <= p_p6_d;
        end
    end

    assign P = p_p6_q;

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Scoreboard bench for pipelined_multiplier: every sampling edge queues its expected product.
module tb_pipelined_multiplier;
    localparam int W   = 32;
    localparam int LAT = 6;

    typedef struct {
        int unsigned   due;
        logic [63:0]   exp;
    } exp_t;

    logic            CLK = 1'b0;
    logic            rst_n;
    logic [W-1:0]    A;
    logic [W-1:0]    B;
    logic [2*W-1:0]  P;

    exp_t            sb[$];
    int unsigned     total  = 0;
    int unsigned     bad    = 0;
    int unsigned     edge_n = 0;
    logic            pend_known = 1'b0;
    logic [63:0]     pend_exp   = '0;

    pipelined_multiplier #(.WIDTH(W), .LATENCY(LAT)) dut (
        .CLK(CLK), .rst_n(rst_n), .A(A), .B(B), .P(P)
    );

    always #5 CLK = ~CLK;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint unsigned x, y;
        x = a;
        y = b;
        return x * y;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic known, input logic [63:0] exp);
        @(negedge CLK);
        A          = a;
        B          = b;
        pend_known = known;
        pend_exp   = exp;
    endtask

    // In-flight products are lost the instant reset asserts
    always @(negedge rst_n) sb.delete();

    // Record what this edge samples, then check what P shows just after it
    always @(posedge CLK) begin
        exp_t e;
        edge_n++;
        if (rst_n === 1'b1) begin
            e.due = edge_n + LAT - 1;
            e.exp = pend_known ? pend_exp : ref_mul(A, B);
            sb.push_back(e);
        end
        #1;
        if (rst_n !== 1'b1) begin
            check("reset_hold", P, 64'd0);
        end else if (sb.size() > 0 && sb[0].due == edge_n) begin
            check("result", P, sb[0].exp);
            void'(sb.pop_front());
        end else begin
            check("fill_zero", P, 64'd0);
        end
    end

    initial begin
        rst_n = 1'b0;
        A     = 32'd5;
        B     = 32'd7;
        repeat (4) @(negedge CLK);
        rst_n      = 1'b1;
        A          = 32'd3;
        B          = 32'd4;
        pend_known = 1'b1;
        pend_exp   = 64'd12;
        repeat (8) @(negedge CLK);

        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFE00000001);
        issue(32'h00000000, 32'hDEADBEEF, 1'b1, 64'h0);
        issue(32'h00000001, 32'h80000000, 1'b1, 64'h0000000080000000);

        issue(32'd2,        32'd3,        1'b1, 64'd6);
        issue(32'd10,       32'd10,       1'b1, 64'd100);
        issue(32'h00010000, 32'h00010000, 1'b1, 64'h0000000100000000);
        issue(32'hFFFFFFFF, 32'd2,        1'b1, 64'h00000001FFFFFFFE);

        issue(32'hFFFFFFFD, 32'd7,        1'b1, 64'h00000006FFFFFFEB);
        repeat (LAT + 1) @(negedge CLK);
        check("fu_mul_low32", {32'd0, P[31:0]}, {32'd0, 32'hFFFFFFEB});

        for (int i = 0; i < 3; i++) issue($urandom, $urandom, 1'b0, 64'd0);
        @(posedge CLK);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_clear", P, 64'd0);
        @(negedge CLK);
        rst_n      = 1'b1;
        A          = $urandom;
        B          = $urandom;
        pend_known = 1'b0;
        repeat (2) @(negedge CLK);

        for (int i = 0; i < 10000; i++) begin
            logic [31:0] ra, rb;
            ra = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFF : $urandom;
            rb = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFF : $urandom;
            if ($urandom_range(0, 31) == 0) ra = 32'd0;
            issue(ra, rb, 1'b0, 64'd0);
        end

        repeat (LAT + 2) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
